// File: rtl/uart_tx_sequencer.sv
// Transmit character sequencer: queues host characters and hands them one at a time
// to the UART TX engine over start_tx/ack/done, with idle gap and frame watchdog.
module uart_tx_sequencer #(
  parameter int DEPTH       = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_valid_i,
  input  logic [DATA_W-1:0]      push_data_i,
  output logic                   push_ready_o,
  input  logic                   flush_i,
  input  logic                   enable_i,
  input  logic [7:0]             gap_cycles_i,
  input  logic                   overflow_clr_i,
  input  logic                   timeout_clr_i,
  output logic                   start_tx_o,
  output logic [DATA_W-1:0]      tx_data_o,
  input  logic                   tx_start_ack_i,
  input  logic                   tx_done_i,
  output logic [$clog2(DEPTH):0] fifo_count_o,
  output logic                   fifo_empty_o,
  output logic                   fifo_full_o,
  output logic                   busy_o,
  output logic                   frame_sent_o,
  output logic                   overflow_o,
  output logic                   timeout_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(TIMEOUT_CYC);
  localparam logic             WD_EN   = (TIMEOUT_CYC > 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_s;
  logic [WD_W-1:0]   wd_r;
  logic [WD_W-1:0]   wd_s;
  logic [7:0]        gap_r;
  logic [7:0]        gap_s;
  logic              empty_r, empty_s, full_r, full_s, ready_r;
  logic              start_tx_r, start_tx_s;
  logic [DATA_W-1:0] tx_data_r, tx_data_s;
  logic              busy_r, busy_s, frame_sent_r, frame_sent_s;
  logic              overflow_r, overflow_s, timeout_r, timeout_s;
  logic              push_acc_s, pop_s, ack_s, done_s, expire_s, in_frame_s;

  assign in_frame_s = (state_r == REQ) || (state_r == WAIT_DONE);
  assign push_acc_s = push_valid_i && !full_r && !flush_i;
  assign pop_s      = (state_r == IDLE) && enable_i && !empty_r && !flush_i;
  // An acknowledge only counts once the request is actually visible on start_tx_o.
  assign ack_s      = tx_start_ack_i && start_tx_r;
  assign done_s     = tx_done_i && ((state_r == WAIT_DONE) || ((state_r == REQ) && ack_s));
  assign expire_s   = WD_EN && in_frame_s && (wd_r == {WD_W{1'b0}}) && !done_s;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; completion beats watchdog expiry in the same cycle
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pop_s) next_state_s = REQ;
        else       next_state_s = IDLE;
      end
      REQ, WAIT_DONE: begin
        if (done_s)                next_state_s = (gap_cycles_i == 8'd0) ? IDLE : GAP;
        else if (expire_s)         next_state_s = IDLE;
        else if (state_r == REQ && ack_s) next_state_s = WAIT_DONE;
        else                       next_state_s = state_r;
      end
      GAP: begin
        if (gap_r <= 8'd1) next_state_s = IDLE;
        else               next_state_s = GAP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output logic: next values of the registered handshake/status outputs
  always_comb begin
    start_tx_s   = (state_r == REQ) && (next_state_s == REQ);
    busy_s       = (next_state_s != IDLE);
    frame_sent_s = done_s;
    if (pop_s) tx_data_s = mem_r[rd_ptr_r];
    else       tx_data_s = tx_data_r;
    if (timeout_clr_i) timeout_s = 1'b0;
    else if (expire_s) timeout_s = 1'b1;
    else               timeout_s = timeout_r;
    if (overflow_clr_i)                            overflow_s = 1'b0;
    else if (push_valid_i && full_r && !flush_i)   overflow_s = 1'b1;
    else                                           overflow_s = overflow_r;
  end

  // FIFO occupancy, watchdog and gap counter next values
  always_comb begin
    if (flush_i) begin
      count_s = {CNT_W{1'b0}};
    end else begin
      case ({push_acc_s, pop_s})
        2'b10:   count_s = count_r + CNT_W'(1);
        2'b01:   count_s = count_r - CNT_W'(1);
        default: count_s = count_r;
      endcase
    end
    empty_s = (count_s == {CNT_W{1'b0}});
    full_s  = (count_s == DEPTH_C);
    if (pop_s)                                    wd_s = WD_LOAD;
    else if (in_frame_s && wd_r != {WD_W{1'b0}}) wd_s = wd_r - WD_W'(1);
    else                                          wd_s = wd_r;
    if (done_s)              gap_s = gap_cycles_i;
    else if (state_r == GAP) gap_s = gap_r - 8'd1;
    else                     gap_s = gap_r;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      empty_r      <= 1'b1;
      full_r       <= 1'b0;
      ready_r      <= 1'b1;
      wd_r         <= {WD_W{1'b0}};
      gap_r        <= 8'd0;
      start_tx_r   <= 1'b0;
      tx_data_r    <= {DATA_W{1'b0}};
      busy_r       <= 1'b0;
      frame_sent_r <= 1'b0;
      overflow_r   <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      if (flush_i) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (push_acc_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        if (pop_s)      rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r      <= count_s;
      empty_r      <= empty_s;
      full_r       <= full_s;
      ready_r      <= !full_s;
      wd_r         <= wd_s;
      gap_r        <= gap_s;
      start_tx_r   <= start_tx_s;
      tx_data_r    <= tx_data_s;
      busy_r       <= busy_s;
      frame_sent_r <= frame_sent_s;
      overflow_r   <= overflow_s;
      timeout_r    <= timeout_s;
    end
  end

  // Character storage
  always_ff @(posedge clk) begin
    if (push_acc_s) mem_r[wr_ptr_r] <= push_data_i;
  end

  assign push_ready_o = ready_r;
  assign start_tx_o   = start_tx_r;
  assign tx_data_o    = tx_data_r;
  assign fifo_count_o = count_r;
  assign fifo_empty_o = empty_r;
  assign fifo_full_o  = full_r;
  assign busy_o       = busy_r;
  assign frame_sent_o = frame_sent_r;
  assign overflow_o   = overflow_r;
  assign timeout_o    = timeout_r;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: directed table/sequences plus a
// randomized run against a queue-and-timeline reference model.
module tb_uart_tx_sequencer;
  localparam int DEPTH = 8;
  localparam int TMO   = 24;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       push_valid_i, flush_i, enable_i, overflow_clr_i, timeout_clr_i;
  logic [7:0] push_data_i, gap_cycles_i;
  logic       tx_start_ack_i, tx_done_i;
  logic       push_ready_o, start_tx_o, fifo_empty_o, fifo_full_o;
  logic       busy_o, frame_sent_o, overflow_o, timeout_o;
  logic [7:0] tx_data_o;
  logic [3:0] fifo_count_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [3:0] exp_count;
    logic       exp_ready;
    logic       exp_ovf;
  } vec_t;
  vec_t vecs [10];

  uart_tx_sequencer #(.DEPTH(DEPTH), .DATA_W(8), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .push_valid_i(push_valid_i), .push_data_i(push_data_i), .push_ready_o(push_ready_o),
    .flush_i(flush_i), .enable_i(enable_i), .gap_cycles_i(gap_cycles_i),
    .overflow_clr_i(overflow_clr_i), .timeout_clr_i(timeout_clr_i),
    .start_tx_o(start_tx_o), .tx_data_o(tx_data_o),
    .tx_start_ack_i(tx_start_ack_i), .tx_done_i(tx_done_i),
    .fifo_count_o(fifo_count_o), .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o),
    .busy_o(busy_o), .frame_sent_o(frame_sent_o),
    .overflow_o(overflow_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    push_valid_i = 1'b0; push_data_i = 8'h00; flush_i = 1'b0;
    overflow_clr_i = 1'b0; timeout_clr_i = 1'b0;
    tx_start_ack_i = 1'b0; tx_done_i = 1'b0;
  endtask

  task automatic push_one(input logic [7:0] d);
    push_valid_i = 1'b1; push_data_i = d;
    tick();
    push_valid_i = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (start_tx_o !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk1({name, "_start_seen"}, start_tx_o, 1'b1);
  endtask

  // Acknowledge and complete in the same cycle; the pulse must follow.
  task automatic finish_frame(input string name);
    tx_start_ack_i = 1'b1; tx_done_i = 1'b1;
    tick();
    tx_start_ack_i = 1'b0; tx_done_i = 1'b0;
    chk1({name, "_sent"}, frame_sent_o, 1'b1);
  endtask

  task automatic check_reset_values(input string name);
    chk1({name, "_start"}, start_tx_o, 1'b0);
    chkv({name, "_data"}, 32'(tx_data_o), 32'h0);
    chkv({name, "_count"}, 32'(fifo_count_o), 32'h0);
    chk1({name, "_empty"}, fifo_empty_o, 1'b1);
    chk1({name, "_full"}, fifo_full_o, 1'b0);
    chk1({name, "_ready"}, push_ready_o, 1'b1);
    chk1({name, "_busy"}, busy_o, 1'b0);
    chk1({name, "_sent"}, frame_sent_o, 1'b0);
    chk1({name, "_ovf"}, overflow_o, 1'b0);
    chk1({name, "_tmo"}, timeout_o, 1'b0);
  endtask

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_time_limit: got no finish expected finish before limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    bit seen_a, seen_b;
    int idle_from, busy_lo, busy_hi, start_lo, start_hi, ack_c, done_c, sent_c, gap_f, sz;
    logic [7:0] mq [$];
    logic [7:0] cur;
    bit ovf, en, fl, pv, oclr;
    logic [7:0] pd;

    for (int i = 0; i < 9; i++)
      vecs[i] = '{valid: 1'b1, data: 8'(i + 1), exp_count: 4'((i < 8) ? i + 1 : 8),
                  exp_ready: (i < 7), exp_ovf: (i == 8)};
    vecs[9] = '{valid: 1'b0, data: 8'h00, exp_count: 4'd8, exp_ready: 1'b0, exp_ovf: 1'b1};

    // Reset state
    reset_n = 1'b0; idle_inputs(); enable_i = 1'b0; gap_cycles_i = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset_n = 1'b1;

    // Test 1: single frame, ack at cycle 4, done at cycle 20
    enable_i = 1'b1;
    push_valid_i = 1'b1; push_data_i = 8'h55;
    for (int cyc = 0; cyc <= 22; cyc++) begin
      tick();
      push_valid_i = 1'b0;
      tx_start_ack_i = (cyc == 4);
      tx_done_i = (cyc == 20);
      chk1("t1_start", start_tx_o, (cyc >= 2 && cyc <= 4));
      chk1("t1_busy", busy_o, (cyc >= 1 && cyc <= 20));
      chk1("t1_sent", frame_sent_o, (cyc == 21));
      if (cyc >= 1) chkv("t1_data", 32'(tx_data_o), 32'h55);
      if (cyc == 0) chkv("t1_count", 32'(fifo_count_o), 32'd1);
    end
    idle_inputs();
    chk1("t1_empty", fifo_empty_o, 1'b1);

    // Test 2: fill past full with enable low, then drain in order
    enable_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_valid_i = vecs[i].valid; push_data_i = vecs[i].data;
      tick();
      chkv("t2_count", 32'(fifo_count_o), 32'(vecs[i].exp_count));
      chk1("t2_ready", push_ready_o, vecs[i].exp_ready);
      chk1("t2_full", fifo_full_o, !vecs[i].exp_ready);
      chk1("t2_ovf", overflow_o, vecs[i].exp_ovf);
    end
    push_valid_i = 1'b1; push_data_i = 8'hEE; overflow_clr_i = 1'b1;
    tick();
    idle_inputs();
    chk1("t2_clr_wins", overflow_o, 1'b0);
    chkv("t2_count_held", 32'(fifo_count_o), 32'd8);
    enable_i = 1'b1;
    for (int j = 0; j < 8; j++) begin
      wait_start("t2");
      chkv("t2_order", 32'(tx_data_o), 32'(j + 1));
      finish_frame("t2");
    end
    tick();
    chk1("t2_drained", fifo_empty_o, 1'b1);

    // Test 3: gap of 3 between two frames
    enable_i = 1'b0;
    push_one(8'hA1); push_one(8'hA2);
    enable_i = 1'b1;
    wait_start("t3a");
    chkv("t3_data1", 32'(tx_data_o), 32'hA1);
    tx_start_ack_i = 1'b1; tick(); tx_start_ack_i = 1'b0;
    gap_cycles_i = 8'd3; tx_done_i = 1'b1; tick(); tx_done_i = 1'b0; gap_cycles_i = 8'd200;
    for (int i = 1; i <= 6; i++) begin
      chk1("t3_busy", busy_o, (i <= 3) || (i >= 5));
      chk1("t3_start", start_tx_o, (i == 6));
      chk1("t3_sent", frame_sent_o, (i == 1));
      if (i == 5) chkv("t3_data2", 32'(tx_data_o), 32'hA2);
      if (i < 6) tick();
    end
    gap_cycles_i = 8'd0;
    finish_frame("t3b");

    // Test 4: watchdog with no acknowledge
    enable_i = 1'b0;
    push_one(8'h11); push_one(8'h22);
    enable_i = 1'b1;
    wait_start("t4");
    enable_i = 1'b0;
    n = 1; seen_a = 1'b0;
    for (int g = 0; g < 100; g++) begin
      tick();
      if (frame_sent_o === 1'b1) seen_a = 1'b1;
      if (start_tx_o !== 1'b1) break;
      n++;
    end
    chkv("t4_high_cycles", n, TMO);
    chk1("t4_timeout", timeout_o, 1'b1);
    chk1("t4_idle", busy_o, 1'b0);
    chk1("t4_no_sent", seen_a, 1'b0);
    chkv("t4_count", 32'(fifo_count_o), 32'd1);
    timeout_clr_i = 1'b1; tick(); timeout_clr_i = 1'b0;
    chk1("t4_cleared", timeout_o, 1'b0);
    enable_i = 1'b1;
    wait_start("t4b");
    chkv("t4_next_data", 32'(tx_data_o), 32'h22);
    finish_frame("t4b");

    // Test 5: flush while a frame is in flight
    enable_i = 1'b0;
    push_one(8'h31); push_one(8'h32); push_one(8'h33); push_one(8'h34);
    enable_i = 1'b1;
    wait_start("t5");
    chkv("t5_data", 32'(tx_data_o), 32'h31);
    chkv("t5_count3", 32'(fifo_count_o), 32'd3);
    tx_start_ack_i = 1'b1; tick(); tx_start_ack_i = 1'b0;
    flush_i = 1'b1; push_valid_i = 1'b1; push_data_i = 8'hAA;
    tick();
    idle_inputs();
    chkv("t5_count0", 32'(fifo_count_o), 32'd0);
    chk1("t5_ovf", overflow_o, 1'b0);
    chk1("t5_busy", busy_o, 1'b1);
    tx_done_i = 1'b1; tick(); tx_done_i = 1'b0;
    chk1("t5_sent", frame_sent_o, 1'b1);
    seen_a = 1'b0;
    repeat (20) begin
      tick();
      if (start_tx_o === 1'b1) seen_a = 1'b1;
    end
    chk1("t5_no_start", seen_a, 1'b0);

    // Test 6: asynchronous reset during REQ
    enable_i = 1'b0;
    push_one(8'h41); push_one(8'h42); push_one(8'h43);
    enable_i = 1'b1;
    wait_start("t6");
    #2 reset_n = 1'b0;
    #1;
    check_reset_values("t6_async");
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    seen_a = 1'b0; seen_b = 1'b0;
    repeat (15) begin
      tick();
      if (start_tx_o === 1'b1) seen_a = 1'b1;
      if (busy_o === 1'b1) seen_b = 1'b1;
    end
    chk1("t6_no_start", seen_a, 1'b0);
    chk1("t6_no_busy", seen_b, 1'b0);
    push_one(8'h5A);
    wait_start("t6b");
    chkv("t6_data", 32'(tx_data_o), 32'h5A);
    finish_frame("t6b");
    tick(); tick();

    // Randomized run against a queue + timeline model
    idle_from = 0; busy_lo = 1; busy_hi = 0; start_lo = 1; start_hi = 0;
    ack_c = -1; done_c = -1; sent_c = -1; gap_f = 0;
    cur = 8'h5A; ovf = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      sz = mq.size();
      chk1("r_start", start_tx_o, (k >= start_lo && k <= start_hi));
      chk1("r_busy", busy_o, (k >= busy_lo && k <= busy_hi));
      chk1("r_sent", frame_sent_o, (k == sent_c));
      chkv("r_data", 32'(tx_data_o), 32'(cur));
      chkv("r_count", 32'(fifo_count_o), 32'(sz));
      chk1("r_empty", fifo_empty_o, (sz == 0));
      chk1("r_full", fifo_full_o, (sz == DEPTH));
      chk1("r_ready", push_ready_o, (sz != DEPTH));
      chk1("r_ovf", overflow_o, ovf);
      chk1("r_tmo", timeout_o, 1'b0);

      en = ($urandom_range(0, 9) < 8);
      fl = ($urandom_range(0, 49) == 0);
      pv = ($urandom_range(0, 2) != 0);
      pd = 8'($urandom);
      oclr = ($urandom_range(0, 29) == 0);
      enable_i = en; flush_i = fl; push_valid_i = pv; push_data_i = pd;
      overflow_clr_i = oclr;
      tx_start_ack_i = (k == ack_c);
      tx_done_i = (k == done_c)
                  || (k >= busy_lo && k < ack_c && $urandom_range(0, 3) == 0)
                  || (k > done_c && $urandom_range(0, 19) == 0);
      gap_cycles_i = (k == done_c) ? 8'(gap_f) : 8'($urandom);

      if (k >= idle_from && en && sz > 0 && !fl) begin
        cur = mq.pop_front();
        gap_f = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
        busy_lo = k + 1;
        start_lo = k + 2;
        ack_c = k + 2 + $urandom_range(0, 4);
        start_hi = ack_c;
        done_c = ack_c + $urandom_range(0, 5);
        sent_c = done_c + 1;
        busy_hi = done_c + gap_f;
        idle_from = done_c + gap_f + 1;
      end
      if (pv && !fl) begin
        if (sz < DEPTH) mq.push_back(pd);
        else if (!oclr) ovf = 1'b1;
      end
      if (oclr) ovf = 1'b0;
      if (fl) mq.delete();
      tick();
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
